// File: rtl/hilo_if.sv
// Bundle between hilo_seq and its neighbours: control unit, multiplier and datapath.
// The slave side is the sequencer; the master side drives requests and the product.
interface hilo_if;
    logic        start;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic [31:0] mult_hi;
    logic [31:0] mult_lo;
    logic        mult_ctrl;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, mthi, mtlo, wdata, mult_hi, mult_lo,
        input  mult_ctrl, busy, done, hi, lo
    );

    modport slave (
        input  start, mthi, mtlo, wdata, mult_hi, mult_lo,
        output mult_ctrl, busy, done, hi, lo
    );
endinterface

// File: rtl/hilo_seq.sv
// Multiply sequencer and architectural HI/LO holder sitting behind the shift-add multiplier.
//
// state | meaning
// IDLE  | waiting for start; services mthi/mtlo writes
// LOAD  | multiplier samples its operands (mult_ctrl=1)
// RUN   | one multiplier iteration per edge; cnt counts down to 0
// CAPT  | product stable; HI/LO take it and done pulses
module hilo_seq #(
    parameter int ITER = 32,
    parameter int CW   = 6
) (
    input  logic  clk,
    input  logic  reset,
    hilo_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, CAPT} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [31:0]     hi_q, hi_nxt;
    logic [31:0]     lo_q, lo_nxt;
    logic            done_q, done_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            hi_q   <= hi_nxt;
            lo_q   <= lo_nxt;
            done_q <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hi_nxt    = hi_q;
        lo_nxt    = lo_q;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                // start wins over a same-cycle register write
                if (bus.start) begin
                    state_nxt = LOAD;
                end else begin
                    if (bus.mthi) hi_nxt = bus.wdata;
                    if (bus.mtlo) lo_nxt = bus.wdata;
                end
            end
            LOAD: begin
                state_nxt = RUN;
                cnt_nxt   = CW'(ITER - 1);
            end
            RUN: begin
                if (cnt == '0) state_nxt = CAPT;
                else           cnt_nxt   = cnt - CW'(1);
            end
            CAPT: begin
                hi_nxt    = bus.mult_hi;
                lo_nxt    = bus.mult_lo;
                done_nxt  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.mult_ctrl = (state == LOAD);
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
endmodule

// File: tb/tb_hilo_seq.sv
// Bench for hilo_seq: a behavioural signed shift-add multiplier feeds the product,
// a vector table drives multiplies, and hand sequences cover writes and mid-run reset.
module tb_hilo_seq;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    hilo_if bus ();

    hilo_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Signed multiplier model: magnitudes are shift-added, sign applied on the output.
    logic [31:0] op_a = '0, op_b = '0;
    logic [63:0] m_acc = '0, m_mc = '0;
    logic [31:0] m_mp = '0;
    logic        m_neg = 1'b0;
    logic [63:0] prod;

    always @(posedge clk) begin
        if (bus.mult_ctrl) begin
            m_acc <= '0;
            m_mc  <= {32'b0, (op_a[31] ? -op_a : op_a)};
            m_mp  <= op_b[31] ? -op_b : op_b;
            m_neg <= op_a[31] ^ op_b[31];
        end else begin
            if (m_mp[0]) m_acc <= m_acc + m_mc;
            m_mc <= m_mc << 1;
            m_mp <= m_mp >> 1;
        end
    end

    assign prod        = m_neg ? -m_acc : m_acc;
    assign bus.mult_hi = prod[63:32];
    assign bus.mult_lo = prod[31:0];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        bit          b2b;
        bit          wr_with_start;
        bit          disturb;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_mult(input int idx, input vec_t v);
        logic [31:0] hi0, lo0;
        int          j_done, busy_n, ctrl_n;
        logic        ctrl_first;
        if (!v.b2b) begin
            repeat (2) tick();
        end else begin
            check($sformatf("v%0d_b2b_done", idx), 64'(bus.done), 64'd1);
        end
        hi0 = bus.hi;
        lo0 = bus.lo;
        op_a = v.a;
        op_b = v.b;
        bus.start = 1'b1;
        if (v.wr_with_start) begin
            bus.mthi  = 1'b1;
            bus.mtlo  = 1'b1;
            bus.wdata = 32'hCAFEF00D;
        end
        j_done = -1;
        busy_n = 0;
        ctrl_n = 0;
        ctrl_first = 1'b0;
        for (int j = 0; j < 100 && j_done < 0; j++) begin
            tick();
            if (j == 0) begin
                bus.start = 1'b0;
                bus.mthi  = 1'b0;
                bus.mtlo  = 1'b0;
                ctrl_first = bus.mult_ctrl;
                if (v.wr_with_start)
                    check($sformatf("v%0d_wr_dropped", idx), {bus.hi, bus.lo}, {hi0, lo0});
            end
            if (v.disturb && j == 10) begin
                bus.start = 1'b1;
                bus.mthi  = 1'b1;
                bus.mtlo  = 1'b1;
                bus.wdata = 32'h0;
            end
            if (v.disturb && j == 11) begin
                bus.start = 1'b0;
                bus.mthi  = 1'b0;
                bus.mtlo  = 1'b0;
                check($sformatf("v%0d_busy_wr_ignored", idx), {bus.hi, bus.lo}, {hi0, lo0});
            end
            if (bus.busy) busy_n++;
            if (bus.mult_ctrl) ctrl_n++;
            if (bus.done) j_done = j;
        end
        check($sformatf("v%0d_latency", idx), 64'(j_done), 64'd34);
        check($sformatf("v%0d_busy_cycles", idx), 64'(busy_n), 64'd34);
        check($sformatf("v%0d_ctrl_cycles", idx), 64'(ctrl_n), 64'd1);
        check($sformatf("v%0d_ctrl_first", idx), 64'(ctrl_first), 64'd1);
        check($sformatf("v%0d_hi", idx), 64'(bus.hi), 64'(v.exp_hi));
        check($sformatf("v%0d_lo", idx), 64'(bus.lo), 64'(v.exp_lo));
        if (v.disturb) begin
            tick();
            check($sformatf("v%0d_single_done", idx), {62'd0, bus.busy, bus.done}, 64'd0);
        end
    endtask

    vec_t vecs [6];

    initial begin
        vecs[0] = '{32'd7,        32'd6,        32'h00000000, 32'h0000002A, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1};

        reset     = 1'b0;
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        bus.wdata = '0;
        #3;
        check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        check("rst_ctrl", {61'd0, bus.busy, bus.done, bus.mult_ctrl}, 64'd0);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        check("post_rst_idle", {61'd0, bus.busy, bus.done, bus.mult_ctrl}, 64'd0);

        bus.mthi  = 1'b1;
        bus.wdata = 32'hDEADBEEF;
        tick();
        bus.mthi = 1'b0;
        check("mthi", {bus.hi, bus.lo}, {32'hDEADBEEF, 32'h0});
        bus.mtlo  = 1'b1;
        bus.wdata = 32'h12345678;
        tick();
        bus.mtlo = 1'b0;
        check("mtlo", {bus.hi, bus.lo}, {32'hDEADBEEF, 32'h12345678});
        bus.mthi  = 1'b1;
        bus.mtlo  = 1'b1;
        bus.wdata = 32'hA5A5A5A5;
        tick();
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        check("mthi_mtlo", {bus.hi, bus.lo}, {32'hA5A5A5A5, 32'hA5A5A5A5});

        for (int i = 0; i < 6; i++) run_mult(i, vecs[i]);

        // Reset in the middle of RUN: no capture, no done, full restart afterwards.
        repeat (2) tick();
        op_a = 32'd9;
        op_b = 32'd9;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (11) tick();
        check("mid_busy", 64'(bus.busy), 64'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_hilo", {bus.hi, bus.lo}, 64'd0);
        check("mid_rst_ctrl", {61'd0, bus.busy, bus.done, bus.mult_ctrl}, 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("mid_rst_hold", {61'd0, bus.busy, bus.done, bus.mult_ctrl}, 64'd0);
        end
        reset = 1'b1;
        run_mult(6, '{32'd2, 32'd3, 32'h0, 32'h6, 1'b0, 1'b0, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
